// File: rtl/servo_pkg.sv
// Shared types and constants for the servo dispenser controller.
// Imported by the channel and top-level modules.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE_RET,
    MOVE_EXT,
    IDLE_EXT,
    MOVE_RET
  } servo_state_t;

  localparam int unsigned US_PER_MS = 1000;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: button sync, debounce integrator,
// extend/retract travel FSM and frame-locked PWM.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned PULSE_RET_US = 1000,
  parameter int unsigned PULSE_EXT_US = 2000,
  parameter int unsigned TRAVEL_MS    = 1000,
  parameter int unsigned DEB_MS       = 1000,
  parameter int unsigned DEB_THRESH   = 750,
  parameter int unsigned HOLD         = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic tick_us_i,
  input  logic tick_ms_i,
  input  logic frame_start_i,
  output logic servo_o,
  output logic busy_o,
  output logic done_o,
  output logic extended_o
);

  localparam int unsigned LW = $clog2(DEB_MS + 1);
  localparam int unsigned TW = $clog2(TRAVEL_MS + 1);
  localparam int unsigned WW =
    $clog2(max2(PULSE_EXT_US, PULSE_RET_US) + 1);

  localparam logic [LW-1:0] LVL_MAX = LW'(DEB_MS);
  localparam logic [LW-1:0] LVL_TH  = LW'(DEB_THRESH);
  localparam logic [TW-1:0] TRAV    = TW'(TRAVEL_MS);
  localparam logic [WW-1:0] W_EXT   = WW'(PULSE_EXT_US);
  localparam logic [WW-1:0] W_RET   = WW'(PULSE_RET_US);

  logic [1:0]    sync_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          pressed_q, pressed_d;
  servo_state_t  state_q, state_d;
  logic [TW-1:0] travel_q, travel_d;
  logic          done_q, done_d;
  logic [WW-1:0] width_q, width_d;
  logic          servo_q, servo_d;
  logic          btn_s, busy, ext;

  assign btn_s = sync_q[1];
  assign busy  = (state_q == MOVE_EXT) || (state_q == MOVE_RET);
  assign ext   = (state_q == MOVE_EXT) || (state_q == IDLE_EXT);

  always_comb begin
    lvl_d = lvl_q;
    if (tick_ms_i) begin
      if (btn_s) begin
        if (lvl_q != LVL_MAX) lvl_d = lvl_q + 1'b1;
      end else if (lvl_q != '0) begin
        lvl_d = lvl_q - 1'b1;
      end
    end
    pressed_d = (lvl_q > LVL_TH);
  end

  always_comb begin
    state_d  = state_q;
    travel_d = travel_q;
    done_d   = 1'b0;
    if (tick_ms_i) begin
      unique case (state_q)
        IDLE_RET: begin
          if (pressed_q) begin
            state_d  = MOVE_EXT;
            travel_d = TRAV;
          end
        end
        IDLE_EXT: begin
          if (!pressed_q) begin
            state_d  = MOVE_RET;
            travel_d = TRAV;
          end
        end
        MOVE_EXT, MOVE_RET: begin
          if (travel_q == TW'(1)) begin
            state_d = (state_q == MOVE_EXT) ? IDLE_EXT : IDLE_RET;
            done_d  = 1'b1;
          end else begin
            travel_d = travel_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Width is sampled only at frame start so mid-pulse moves never reshape it
  always_comb begin
    width_d = width_q;
    if (frame_start_i && (busy || (HOLD != 0))) begin
      width_d = ext ? W_EXT : W_RET;
    end else if (tick_us_i && (width_q != '0)) begin
      width_d = width_q - 1'b1;
    end
    servo_d = (width_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      lvl_q     <= '0;
      pressed_q <= 1'b0;
      state_q   <= MOVE_RET;
      travel_q  <= TRAV;
      done_q    <= 1'b0;
      width_q   <= '0;
      servo_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      lvl_q     <= lvl_d;
      pressed_q <= pressed_d;
      state_q   <= state_d;
      travel_q  <= travel_d;
      done_q    <= done_d;
      width_q   <= width_d;
      servo_q   <= servo_d;
    end
  end

  assign servo_o    = servo_q;
  assign busy_o     = busy;
  assign done_o     = done_q;
  assign extended_o = ext;

endmodule

// File: rtl/servo_array_ctrl.sv
// N-channel servo dispenser: shared us/ms/frame timebase,
// heartbeat LED and one servo_channel per button.
module servo_array_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned N_CH         = 2,
  parameter int unsigned FRAME_US     = 20000,
  parameter int unsigned PULSE_RET_US = 1000,
  parameter int unsigned PULSE_EXT_US = 2000,
  parameter int unsigned TRAVEL_MS    = 1000,
  parameter int unsigned DEB_MS       = 1000,
  parameter int unsigned DEB_THRESH   = 750,
  parameter int unsigned HOLD         = 0
) (
  input  logic            clk_50m,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] servo,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] done,
  output logic [N_CH-1:0] extended,
  output logic            led
);

  localparam int unsigned DIV   = CLK_HZ / 1_000_000;
  localparam int unsigned HB_MS = 500;
  localparam int unsigned PW    = $clog2(DIV + 1);
  localparam int unsigned UW    = $clog2(US_PER_MS + 1);
  localparam int unsigned FW    = $clog2(FRAME_US + 1);
  localparam int unsigned HW    = $clog2(HB_MS + 1);

  if ((CLK_HZ == 0) || (CLK_HZ % 1_000_000 != 0)) begin : g_bad_clk
    $error("CLK_HZ must be a nonzero multiple of 1 MHz");
  end
  if ((N_CH < 1) || (N_CH > 8)) begin : g_bad_nch
    $error("N_CH must be 1..8");
  end
  if (PULSE_EXT_US >= FRAME_US) begin : g_bad_pulse
    $error("PULSE_EXT_US must be below FRAME_US");
  end
  if (TRAVEL_MS < 1) begin : g_bad_travel
    $error("TRAVEL_MS must be at least 1");
  end
  if (DEB_THRESH >= DEB_MS) begin : g_bad_deb
    $error("DEB_THRESH must be below DEB_MS");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic [UW-1:0] us_q, us_d;
  logic [FW-1:0] fr_q, fr_d;
  logic [HW-1:0] hb_q, hb_d;
  logic          led_q, led_d;
  logic          tick_us, tick_ms, frame_start;

  assign tick_us     = (pre_q == PW'(DIV - 1));
  assign tick_ms     = tick_us && (us_q == UW'(US_PER_MS - 1));
  assign frame_start = tick_us && (fr_q == FW'(FRAME_US - 1));

  always_comb begin
    pre_d = tick_us ? '0 : pre_q + 1'b1;
    us_d  = us_q;
    fr_d  = fr_q;
    hb_d  = hb_q;
    led_d = led_q;
    if (tick_us) begin
      us_d = tick_ms ? '0 : us_q + 1'b1;
      fr_d = frame_start ? '0 : fr_q + 1'b1;
    end
    if (tick_ms) begin
      if (hb_q == HW'(HB_MS - 1)) begin
        hb_d  = '0;
        led_d = ~led_q;
      end else begin
        hb_d = hb_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      us_q  <= '0;
      fr_q  <= '0;
      hb_q  <= '0;
      led_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      us_q  <= us_d;
      fr_q  <= fr_d;
      hb_q  <= hb_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    servo_channel #(
      .PULSE_RET_US(PULSE_RET_US),
      .PULSE_EXT_US(PULSE_EXT_US),
      .TRAVEL_MS   (TRAVEL_MS),
      .DEB_MS      (DEB_MS),
      .DEB_THRESH  (DEB_THRESH),
      .HOLD        (HOLD)
    ) u_ch (
      .clk_i        (clk_50m),
      .rst_ni       (rst_n),
      .btn_i        (btn[g]),
      .tick_us_i    (tick_us),
      .tick_ms_i    (tick_ms),
      .frame_start_i(frame_start),
      .servo_o      (servo[g]),
      .busy_o       (busy[g]),
      .done_o       (done[g]),
      .extended_o   (extended[g])
    );
  end

endmodule

// File: tb/tb_servo_array_ctrl.sv
// Scoreboard bench: HOLD=0 and HOLD=1 instances share stimulus,
// a us-level reference model predicts pulses, done and state.
module tb_servo_array_ctrl;

  localparam int DIV   = 2;
  localparam int FRAME = 200;
  localparam int PRET  = 50;
  localparam int PEXT  = 100;
  localparam int TRAV  = 3;
  localparam int DEBMS = 10;
  localparam int TH    = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [1:0] servo [2];
  logic [1:0] busy  [2];
  logic [1:0] done  [2];
  logic [1:0] ext   [2];
  logic       led   [2];

  always #5 clk = ~clk;

  servo_array_ctrl #(
    .CLK_HZ(2_000_000), .N_CH(2), .FRAME_US(FRAME),
    .PULSE_RET_US(PRET), .PULSE_EXT_US(PEXT),
    .TRAVEL_MS(TRAV), .DEB_MS(DEBMS), .DEB_THRESH(TH),
    .HOLD(0)
  ) dut (
    .clk_50m(clk), .rst_n(rst_n), .btn(btn),
    .servo(servo[0]), .busy(busy[0]), .done(done[0]),
    .extended(ext[0]), .led(led[0])
  );

  servo_array_ctrl #(
    .CLK_HZ(2_000_000), .N_CH(2), .FRAME_US(FRAME),
    .PULSE_RET_US(PRET), .PULSE_EXT_US(PEXT),
    .TRAVEL_MS(TRAV), .DEB_MS(DEBMS), .DEB_THRESH(TH),
    .HOLD(1)
  ) dut_h (
    .clk_50m(clk), .rst_n(rst_n), .btn(btn),
    .servo(servo[1]), .busy(busy[1]), .done(done[1]),
    .extended(ext[1]), .led(led[1])
  );

  typedef struct {
    int start_us;
    int width_clk;
  } pulse_t;

  pulse_t pq [4][$];
  int     dq [4][$];
  int     errors = 0;
  int     checks = 0;
  int     k = 0;
  int     npulse [2];

  // Model state per (instance, channel), index = inst*2 + ch
  int lvl [4];
  bit mov [4];
  bit exm [4];
  int rem [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_us(input int t);
    while (k < DIV * t) @(negedge clk);
  endtask

  // Reference model: one step per microsecond boundary
  initial begin
    int u;
    bit pr;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        for (int i = 0; i < 4; i++) begin
          lvl[i] = 0; mov[i] = 1'b1; exm[i] = 1'b0; rem[i] = TRAV;
          pq[i].delete(); dq[i].delete();
        end
        continue;
      end
      if (k % DIV == DIV - 1) begin
        u = (k + 1) / DIV;
        if (u % FRAME == 0) begin
          for (int i = 0; i < 4; i++) begin
            if (mov[i] || (i / 2 == 1))
              pq[i].push_back('{start_us: u,
                width_clk: (exm[i] ? PEXT : PRET) * DIV});
          end
        end
        if (u % 1000 == 0) begin
          for (int i = 0; i < 4; i++) begin
            pr = (lvl[i] > TH);
            if (mov[i]) begin
              rem[i]--;
              if (rem[i] == 0) begin
                mov[i] = 1'b0;
                dq[i].push_back(u);
              end
            end else if (pr != exm[i]) begin
              exm[i] = pr; mov[i] = 1'b1; rem[i] = TRAV;
            end
            if (btn[i % 2]) lvl[i] = (lvl[i] < DEBMS) ? lvl[i] + 1 : DEBMS;
            else            lvl[i] = (lvl[i] > 0) ? lvl[i] - 1 : 0;
          end
        end
      end
      k++;
    end
  end

  // Monitor: measures pulses and done strobes, pops expectations
  initial begin
    int hc [4];
    int st [4];
    pulse_t p;
    for (int i = 0; i < 4; i++) begin hc[i] = 0; st[i] = 0; end
    npulse[0] = 0; npulse[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) hc[i] = 0;
        continue;
      end
      for (int i = 0; i < 4; i++) begin
        if (servo[i / 2][i % 2]) begin
          if (hc[i] == 0) st[i] = k;
          hc[i]++;
        end else if (hc[i] != 0) begin
          npulse[i / 2]++;
          if (pq[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL pulse_unexpected[%0d]: got start %0d expected none",
                     i, st[i]);
          end else begin
            p = pq[i].pop_front();
            check($sformatf("pulse_start[%0d]", i), st[i], p.start_us * DIV);
            check($sformatf("pulse_width[%0d]", i), hc[i], p.width_clk);
          end
          hc[i] = 0;
        end
        if (done[i / 2][i % 2]) begin
          if (dq[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected[%0d]: got cycle %0d expected none",
                     i, k);
          end else begin
            check($sformatf("done_time[%0d]", i), k, dq[i].pop_front() * DIV);
          end
        end
      end
      if (k % 2000 == 1000) begin
        for (int n = 0; n < 2; n++) begin
          check($sformatf("busy[%0d]", n), int'(busy[n]),
                int'({mov[n * 2 + 1], mov[n * 2]}));
          check($sformatf("extended[%0d]", n), int'(ext[n]),
                int'({exm[n * 2 + 1], exm[n * 2]}));
          check($sformatf("led[%0d]", n), int'(led[n]), 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end expected end of run");
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      check($sformatf("rst_servo[%0d]", n), int'(servo[n]), 0);
      check($sformatf("rst_done[%0d]", n), int'(done[n]), 0);
      check($sformatf("rst_ext[%0d]", n), int'(ext[n]), 0);
      check($sformatf("rst_led[%0d]", n), int'(led[n]), 0);
      check($sformatf("rst_busy[%0d]", n), int'(busy[n]), 3);
    end
    rst_n = 1'b1;
    wait_us(5500);  btn = 2'b11;
    wait_us(8500);  btn[1] = 1'b0;
    wait_us(11500); btn[1] = 1'b1;
    wait_us(14500); btn[1] = 1'b0;
    wait_us(15500); btn[0] = 1'b0;
    wait_us(20025);
    check("pre_reset_servo0", int'(servo[0][0]), 1);
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 2; n++)
      check($sformatf("async_rst_servo[%0d]", n), int'(servo[n]), 0);
    repeat (4) @(negedge clk);
    for (int n = 0; n < 2; n++)
      check($sformatf("rst2_busy[%0d]", n), int'(busy[n]), 3);
    rst_n = 1'b1;
    wait_us(5100);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pulses_left[%0d]", i), pq[i].size(), 0);
      check($sformatf("dones_left[%0d]", i), dq[i].size(), 0);
    end
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (npulse[n] < 20) begin
        errors++;
        $display("FAIL pulse_count[%0d]: got %0d expected at least 20",
                 n, npulse[n]);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_array_ctrl.md
# servo_array_ctrl

Parametrised N-channel servo dispenser controller for the candy-dispenser top level. It derives microsecond and millisecond ticks from the board clock, debounces one button per channel, and runs a per-channel extend/retract travel state machine. Each channel emits a standard servo PWM frame. It also drives a 1 Hz heartbeat LED.

## Interface
- CLK_HZ, 50_000_000: input clock frequency; must be an integer multiple of 1_000_000.
- N_CH, 2: number of servo channels, 1..8.
- FRAME_US, 20000: PWM frame period in µs.
- PULSE_RET_US, 1000: pulse width for the retracted position, µs.
- PULSE_EXT_US, 2000: pulse width for the extended position, µs; must be < FRAME_US.
- TRAVEL_MS, 1000: travel time allowed per move, ms, ≥1.
- DEB_MS, 1000: saturation limit of the debounce integrator, ms.
- DEB_THRESH, 750: the integrator level must exceed this for a button to count as pressed; must be < DEB_MS.
- HOLD, 0: 0 = pulses only while a move is in progress; 1 = pulses continuously every frame.
- clk_50m  in  1  system clock (CLK_HZ).
- rst_n  in  1  asynchronous, active-low reset.
- btn  in  N_CH  raw, unsynchronised buttons, active-high.
- servo  out  N_CH  PWM outputs, registered.
- busy  out  N_CH  channel is in a MOVE state.
- done  out  N_CH  one-clk_50m pulse when a move completes.
- extended  out  N_CH  the last commanded position is extended.
- led  out  1  heartbeat, toggles every 500 ms.

## Operation
- btn passes through a 2-FF synchroniser.
- Prescaler counts 0..CLK_HZ/1e6−1; tick_us is a one-cycle strobe at wrap.
- A µs counter runs 0..999 on tick_us; tick_ms strobes at its wrap.
- A frame counter runs 0..FRAME_US−1 on tick_us; frame_start strobes on the tick_us where it wraps to 0.
- Debounce integrator, per channel, 0..DEB_MS, updated on tick_ms:
  - +1 if the synchronised button is 1, saturating at DEB_MS.
  - −1 if it is 0, saturating at 0.
  - pressed <= (lvl > DEB_THRESH), registered.
- FSM per channel, states IDLE_RET, MOVE_EXT, IDLE_EXT, MOVE_RET:
  - IDLE_RET and pressed=1 on tick_ms → MOVE_EXT.
  - IDLE_EXT and pressed=0 on tick_ms → MOVE_RET.
  - Entering a MOVE state loads travel_ctr = TRAVEL_MS.
  - In a MOVE state, travel_ctr decrements on tick_ms. When travel_ctr==1 at a tick_ms, the FSM goes to the matching IDLE state and done pulses in that same cycle.
  - A change in pressed during a MOVE is ignored; it is re-evaluated at the first tick_ms after reaching IDLE.
- PWM per channel:
  - On frame_start, if the state is MOVE or HOLD=1, width_ctr loads PULSE_EXT_US for MOVE_EXT/IDLE_EXT, otherwise PULSE_RET_US.
  - servo is 1 while width_ctr≠0; width_ctr decrements on tick_us.
  - Width is latched at frame_start, so a state change mid-pulse never truncates or extends the current pulse.
- busy = state ∈ {MOVE_EXT, MOVE_RET}; extended = state ∈ {MOVE_EXT, IDLE_EXT}.
- All counters are sized with $clog2(limit+1). Parameter violations trigger an elaboration-time $error.

## Timing
- Reset values:
  - servo=0, done=0, led=0, extended=0.
  - All counters 0; integrator 0.
  - FSM in MOVE_RET with travel_ctr=TRAVEL_MS, so busy=1 during and after reset. The servo is driven to the retracted position on power-up.
- Reset asserted mid-pulse forces servo=0 asynchronously.
- The first frame_start occurs FRAME_US µs after rst_n deasserts.
- Pulse high time is exactly N µs ±1 clk_50m, where N is the latched width.
- Button to FSM latency: 2 clk (sync) + integrator ramp (DEB_THRESH+1 ticks from level 0) + 1 clk (pressed register) + up to 1 ms (next tick_ms).
- A move lasts exactly TRAVEL_MS tick_ms periods.
- tick_us and tick_ms coincide at the ms wrap. Both are processed in the same cycle, with no loss.
- Channels are independent, and all pulses start on the same frame_start.

## Structure
- Package servo_pkg holds:
  - enum servo_state_t {IDLE_RET, MOVE_EXT, IDLE_EXT, MOVE_RET};
  - localparam US_PER_MS = 1000.
- Sub-module servo_channel holds the synchroniser, integrator, FSM and PWM for one channel, and takes tick_us, tick_ms and frame_start as inputs.
- The top level owns the prescaler, µs/ms counters, frame counter and heartbeat, and instantiates N_CH servo_channel via generate.

## Test plan
Bench parameters: CLK_HZ=2_000_000, FRAME_US=200, PULSE_RET_US=50, PULSE_EXT_US=100, TRAVEL_MS=3, DEB_MS=10, DEB_THRESH=7, N_CH=2.
- Reset release, buttons low:
  - busy=2'b11.
  - Retract pulses are 100 clk high, repeating every 400 clk.
  - done pulses in the ms-3 window; busy drops to 0.
  - No pulses after that (HOLD=0).
- btn[0] held high: MOVE_EXT entered 8–9 ms after the press, then 100 µs pulses on servo[0] only. extended=2'b01 after done.
- btn[0] glitches of 3 ms high / 3 ms low: the integrator never exceeds 7, so no state change.
- btn[0] released during MOVE_EXT: the move completes to IDLE_EXT, then MOVE_RET starts at a later tick_ms, once the integrator has decayed to ≤7 (pressed=0).
- HOLD=1: pulses continue every frame in IDLE, with width 50/100 matching extended.
- rst_n asserted mid-pulse: servo falls within the same clk; after release, behaviour matches the first scenario.
